jtag_shift_seq: RTL and testbench
=================================

Name: jtag_shift_seq

Overview:
- Sequencer in front of jtag_proc.
- Accepts one XVC "shift" command of arbitrary bit count and splits it into chunks of at most C_DATA_WIDTH bits.
- Feeds TMS/TDI words to jtag_proc one chunk at a time, runs the en/done handshake, and returns one TDO word per chunk.
- Sits between the command/data streams (driven by the AXI register file or a DMA front end) and jtag_proc's en/done/length/vector ports.

Parameters:
- C_DATA_WIDTH, 32: chunk width, in bits; vector width.
- C_DONE_TIMEOUT, 0: maximum cycles to wait for proc_done per chunk; 0 disables the timeout.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_num_bits  in  32  total bits to shift
- in_valid  in  1  TMS/TDI word available
- in_ready  out  1  word consumed when in_valid && in_ready
- in_tms  in  C_DATA_WIDTH  TMS bits, LSB shifted first
- in_tdi  in  C_DATA_WIDTH  TDI bits, LSB shifted first
- out_valid  out  1  TDO word available
- out_ready  in  1  downstream accepts
- out_tdo  out  C_DATA_WIDTH  captured TDO, LSB first
- out_last  out  1  final word of command
- proc_en  out  1  to jtag_proc en_i
- proc_done  in  1  from jtag_proc done_o
- proc_length  out  32  to jtag_proc length_i
- proc_tms_vec  out  C_DATA_WIDTH  to tms_vec_i
- proc_tdi_vec  out  C_DATA_WIDTH  to tdi_vec_i
- proc_tdo_vec  in  C_DATA_WIDTH  from jtag_proc TDO vector
- busy  out  1  command in progress
- timeout_err  out  1  sticky; set on done timeout, cleared by the next accepted command

Behaviour:
- Reset is synchronous and active-low on s_axi_aresetn, sampled on the rising edge of s_axi_aclk.
- Reset values: cmd_ready=0, in_ready=0, out_valid=0, out_last=0, out_tdo=0, proc_en=0, proc_length=0, proc_tms_vec=0, proc_tdi_vec=0, busy=0, timeout_err=0, state=IDLE, remaining=0.
- IDLE:
  - cmd_ready=1.
  - On accept: remaining<=cmd_num_bits, timeout_err<=0.
  - If cmd_num_bits==0, stay in IDLE; no words are consumed or produced.
  - Otherwise busy<=1 and go to FETCH.
- FETCH:
  - in_ready=1.
  - On accept: proc_tms_vec<=in_tms, proc_tdi_vec<=in_tdi, proc_length<=min(remaining, C_DATA_WIDTH); go to RUN.
  - in_ready is registered-safe: at most one word is consumed per chunk.
- RUN:
  - proc_en=1, held until proc_done is sampled 1.
  - On done: capture proc_tdo_vec, masked so that bits at index >= proc_length are 0.
  - Then remaining<=remaining-proc_length, proc_en<=0, go to RESP.
  - proc_en must drop for at least one cycle between chunks.
  - Timeout counter counts RUN cycles. If C_DONE_TIMEOUT!=0 and the count reaches C_DONE_TIMEOUT: proc_en<=0, timeout_err<=1, go to DRAIN.
- RESP:
  - out_valid=1; out_last=1 iff remaining==0.
  - Hold out_tdo/out_last stable until out_ready.
  - On handshake: go to FETCH if remaining!=0, else go to IDLE with busy<=0.
  - No TDO buffering: backpressure on out stalls the next fetch.
- DRAIN (timeout only):
  - Consume and discard the remaining input words (ceil(remaining/C_DATA_WIDTH)).
  - Emit nothing.
  - Then go to IDLE with busy<=0.
- First-chunk latency: input accept → proc_en high on the next cycle. proc_done seen → out_valid high on the next cycle.
- Simultaneous cmd_valid while busy: cmd_ready=0, so the command is held off.
- proc_done already high on entry to RUN (stale): ignored for the first RUN cycle. done is only accepted after proc_en has been high for at least one cycle.
- Reset mid-operation: immediately forces all reset values, including proc_en=0. Any partially consumed command is discarded.
- remaining arithmetic is 32-bit unsigned; the min/subtract never underflows.

Test Plan:
- cmd_num_bits=32, one word tms=0x0000001F, tdi=0xA5A5A5A5, jtag_proc model returns 0x12345678 → proc_length=32, exactly one out word 0x12345678 with out_last=1, busy low after the handshake.
- cmd_num_bits=70, three words → proc_length sequence 32, 32, 6; third out_tdo has bits[31:6]=0 even when the model returns 0xFFFFFFFF; out_last only on the third word.
- cmd_num_bits=0 → accepted in 1 cycle, in_ready never asserted, no out_valid, busy stays 0.
- out_ready held low for 10 cycles after the first chunk of a 64-bit command → out_tdo stable, in_ready stays 0, no second proc_en until the handshake completes.
- C_DONE_TIMEOUT=16, model never asserts done on a 64-bit command → proc_en falls after 16 cycles, timeout_err=1, second input word drained, no output; next command clears timeout_err.
- s_axi_aresetn=0 for 1 cycle during RUN of a 96-bit command → proc_en=0 and all outputs at reset values next cycle; a new 32-bit command then completes normally.

Source files
------------

// File: rtl/jtag_shift_seq.sv
// Splits one XVC shift command into C_DATA_WIDTH-bit chunks for jtag_proc and
// returns one masked TDO word per chunk, with an optional per-chunk done timeout.
module jtag_shift_seq #(
   parameter int unsigned C_DATA_WIDTH   = 32,
   parameter int unsigned C_DONE_TIMEOUT = 0
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_aresetn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [31:0]             cmd_num_bits,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [C_DATA_WIDTH-1:0] in_tms,
   input  logic [C_DATA_WIDTH-1:0] in_tdi,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [C_DATA_WIDTH-1:0] out_tdo,
   output logic                    out_last,
   output logic                    proc_en,
   input  logic                    proc_done,
   output logic [31:0]             proc_length,
   output logic [C_DATA_WIDTH-1:0] proc_tms_vec,
   output logic [C_DATA_WIDTH-1:0] proc_tdi_vec,
   input  logic [C_DATA_WIDTH-1:0] proc_tdo_vec,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam logic [31:0] W32 = C_DATA_WIDTH;

   typedef enum logic [2:0] {IDLE, FETCH, RUN, RESP, DRAIN} state_t;

   state_t                  state;
   logic [31:0]             remaining;
   logic [31:0]             run_count;
   logic                    done_armed;
   logic [31:0]             chunk_len;
   logic [31:0]             rem_after_run;
   logic [C_DATA_WIDTH-1:0] tdo_mask;

   assign chunk_len     = (remaining > W32) ? W32 : remaining;
   // proc_length was loaded as min(remaining, width), so this cannot underflow
   assign rem_after_run = remaining - proc_length;

   generate
      for (genvar gi = 0; gi < C_DATA_WIDTH; gi++) begin : g_mask
         assign tdo_mask[gi] = (proc_length > 32'(gi));
      end
   endgenerate

   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         cmd_ready    <= 1'b0;
         in_ready     <= 1'b0;
         out_valid    <= 1'b0;
         out_last     <= 1'b0;
         out_tdo      <= '0;
         proc_en      <= 1'b0;
         proc_length  <= '0;
         proc_tms_vec <= '0;
         proc_tdi_vec <= '0;
         busy         <= 1'b0;
         timeout_err  <= 1'b0;
         state        <= IDLE;
         remaining    <= '0;
         run_count    <= '0;
         done_armed   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  remaining   <= cmd_num_bits;
                  timeout_err <= 1'b0;
                  if (cmd_num_bits != 32'd0) begin
                     cmd_ready <= 1'b0;
                     busy      <= 1'b1;
                     in_ready  <= 1'b1;
                     state     <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (in_valid && in_ready) begin
                  proc_tms_vec <= in_tms;
                  proc_tdi_vec <= in_tdi;
                  proc_length  <= chunk_len;
                  in_ready     <= 1'b0;
                  proc_en      <= 1'b1;
                  run_count    <= '0;
                  done_armed   <= 1'b0;
                  state        <= RUN;
               end
            end
            RUN: begin
               // done is ignored during the first RUN cycle so a stale level is never taken
               done_armed <= 1'b1;
               run_count  <= run_count + 32'd1;
               if (done_armed && proc_done) begin
                  out_tdo   <= proc_tdo_vec & tdo_mask;
                  out_last  <= (rem_after_run == 32'd0);
                  out_valid <= 1'b1;
                  remaining <= rem_after_run;
                  proc_en   <= 1'b0;
                  state     <= RESP;
               end else if ((C_DONE_TIMEOUT != 0) && (run_count + 32'd1 == C_DONE_TIMEOUT)) begin
                  proc_en     <= 1'b0;
                  timeout_err <= 1'b1;
                  remaining   <= rem_after_run;
                  if (rem_after_run == 32'd0) begin
                     busy      <= 1'b0;
                     cmd_ready <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     in_ready <= 1'b1;
                     state    <= DRAIN;
                  end
               end
            end
            RESP: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (remaining != 32'd0) begin
                     in_ready <= 1'b1;
                     state    <= FETCH;
                  end else begin
                     busy      <= 1'b0;
                     cmd_ready <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            DRAIN: begin
               if (in_valid && in_ready) begin
                  remaining <= remaining - chunk_len;
                  if (remaining == chunk_len) begin
                     in_ready  <= 1'b0;
                     busy      <= 1'b0;
                     cmd_ready <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_shift_seq.sv
// Directed bench for jtag_shift_seq: reactive jtag_proc model plus scoreboard queues
// for expected chunk launches and expected TDO words.
module tb_jtag_shift_seq;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [31:0]   cmd_num_bits = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_tms = '0;
   logic [W-1:0]  in_tdi = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_tdo;
   logic          out_last;
   logic          proc_en;
   logic          proc_done = 1'b0;
   logic [31:0]   proc_length;
   logic [W-1:0]  proc_tms_vec;
   logic [W-1:0]  proc_tdi_vec;
   logic [W-1:0]  proc_tdo_vec = '0;
   logic          busy;
   logic          timeout_err;

   always #5 clk = ~clk;

   jtag_shift_seq #(.C_DATA_WIDTH(W), .C_DONE_TIMEOUT(16)) dut (
      .s_axi_aclk   (clk),
      .s_axi_aresetn(rstn),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_num_bits (cmd_num_bits),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_tms       (in_tms),
      .in_tdi       (in_tdi),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_tdo      (out_tdo),
      .out_last     (out_last),
      .proc_en      (proc_en),
      .proc_done    (proc_done),
      .proc_length  (proc_length),
      .proc_tms_vec (proc_tms_vec),
      .proc_tdi_vec (proc_tdi_vec),
      .proc_tdo_vec (proc_tdo_vec),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   int tests = 0;
   int fails = 0;

   typedef struct packed { logic [31:0] tdo; logic last; } out_exp_t;
   typedef struct packed { logic [31:0] len; logic [31:0] tms; logic [31:0] tdi; } run_exp_t;
   out_exp_t out_q[$];
   run_exp_t run_q[$];
   out_exp_t mon_o;
   run_exp_t mon_r;

   logic [31:0] model_tdo = '0;
   bit          model_hang = 1'b0;
   int          model_cnt = 0;
   logic        prev_en = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] len_mask(input logic [31:0] len);
      logic [63:0] m;
      m = (64'd1 << len) - 64'd1;
      return m[31:0];
   endfunction

   // jtag_proc model: done pulses two cycles after en rises, unless hung
   always @(negedge clk) begin
      if (!proc_en) begin
         model_cnt = 0;
         proc_done = 1'b0;
      end else if (proc_done) begin
         proc_done = 1'b0;
      end else if (!model_hang) begin
         model_cnt++;
         if (model_cnt >= 2) begin
            proc_done    = 1'b1;
            proc_tdo_vec = model_tdo;
            model_cnt    = 0;
         end
      end
   end

   // monitor: chunk launches and output handshakes against the scoreboard
   always @(negedge clk) begin
      #2;
      if (proc_en && !prev_en) begin
         tests++;
         assert (run_q.size() != 0) else begin
            fails++;
            $error("FAIL run_unexpected observed_len=%0d expected=none", proc_length);
         end
         if (run_q.size() != 0) begin
            mon_r = run_q.pop_front();
            check("proc_length", proc_length, mon_r.len);
            check("proc_tms_vec", proc_tms_vec, mon_r.tms);
            check("proc_tdi_vec", proc_tdi_vec, mon_r.tdi);
         end
      end
      prev_en = proc_en;
      if (out_valid && out_ready) begin
         tests++;
         assert (out_q.size() != 0) else begin
            fails++;
            $error("FAIL out_unexpected observed=%0h expected=none", out_tdo);
         end
         if (out_q.size() != 0) begin
            mon_o = out_q.pop_front();
            check("out_tdo", out_tdo, mon_o.tdo);
            check("out_last", out_last, mon_o.last);
         end
      end
   end

   task automatic send_cmd(input logic [31:0] n);
      int k = 0;
      cmd_num_bits = n;
      cmd_valid    = 1'b1;
      while (!cmd_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("cmd_accept", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] tms, input logic [31:0] tdi, input logic [31:0] tdo);
      int k = 0;
      in_tms   = tms;
      in_tdi   = tdi;
      in_valid = 1'b1;
      while (!in_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("in_accept", in_ready, 1);
      model_tdo = tdo;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic push_chunk(input logic [31:0] rem, input logic [31:0] tms, input logic [31:0] tdi,
                             input logic [31:0] tdo, input bit exp_run, input bit exp_out);
      logic [31:0] len;
      len = (rem > 32) ? 32'd32 : rem;
      if (exp_run) run_q.push_back({len, tms, tdi});
      if (exp_out) out_q.push_back({tdo & len_mask(len), (rem == len)});
      send_word(tms, tdi, tdo);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((busy || out_valid) && k < 500) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_busy"}, busy, 0);
      check({tag, "_outq_left"}, out_q.size(), 0);
      check({tag, "_runq_left"}, run_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_proc_en", proc_en, 0);
      check("rst_busy", busy, 0);
      check("rst_proc_length", proc_length, 0);
      rstn = 1'b1;
      @(negedge clk);

      // single 32-bit chunk
      send_cmd(32);
      push_chunk(32, 32'h0000001F, 32'hA5A5A5A5, 32'h12345678, 1, 1);
      wait_idle("t32");

      // 70 bits: 32, 32, 6 with upper bits of the last word masked
      send_cmd(70);
      push_chunk(70, 32'h11111111, 32'h22222222, 32'hDEADBEEF, 1, 1);
      push_chunk(38, 32'h33333333, 32'h44444444, 32'hCAFEF00D, 1, 1);
      push_chunk(6,  32'h0000003F, 32'h00000015, 32'hFFFFFFFF, 1, 1);
      wait_idle("t70");

      // zero-length command
      send_cmd(0);
      for (int i = 0; i < 5; i++) begin
         check("zero_in_ready", in_ready, 0);
         check("zero_busy", busy, 0);
         @(negedge clk);
      end
      check("zero_cmd_ready", cmd_ready, 1);

      // output backpressure on a 64-bit command
      out_ready = 1'b0;
      send_cmd(64);
      push_chunk(64, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h89ABCDEF, 1, 1);
      c = 0;
      while (!out_valid && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("bp_out_valid", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         check("bp_out_tdo", out_tdo, 32'h89ABCDEF);
         check("bp_in_ready", in_ready, 0);
         check("bp_proc_en", proc_en, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      push_chunk(32, 32'h01234567, 32'h76543210, 32'h55AA55AA, 1, 1);
      wait_idle("bp");

      // done timeout on first chunk of a 64-bit command, second word drained
      model_hang = 1'b1;
      send_cmd(64);
      push_chunk(64, 32'hAAAA0000, 32'h0000BBBB, 32'h0, 1, 0);
      c = 0;
      while (proc_en && c < 100) begin
         @(negedge clk);
         c++;
      end
      check("to_en_cycles", c, 16);
      check("to_err_set", timeout_err, 1);
      check("to_drain_in_ready", in_ready, 1);
      push_chunk(32, 32'h12121212, 32'h34343434, 32'h0, 0, 0);
      wait_idle("to");
      check("to_err_sticky", timeout_err, 1);
      model_hang = 1'b0;
      send_cmd(32);
      check("to_err_cleared", timeout_err, 0);
      push_chunk(32, 32'h00000001, 32'h00000002, 32'h0BADF00D, 1, 1);
      wait_idle("to_next");

      // reset asserted for one cycle during RUN of a 96-bit command
      model_hang = 1'b1;
      send_cmd(96);
      push_chunk(96, 32'hFFFF0000, 32'h0000FFFF, 32'h0, 1, 0);
      repeat (3) @(negedge clk);
      check("mid_run_en", proc_en, 1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check("mr_proc_en", proc_en, 0);
      check("mr_cmd_ready", cmd_ready, 0);
      check("mr_in_ready", in_ready, 0);
      check("mr_out_valid", out_valid, 0);
      check("mr_out_last", out_last, 0);
      check("mr_out_tdo", out_tdo, 0);
      check("mr_busy", busy, 0);
      check("mr_proc_length", proc_length, 0);
      check("mr_proc_tms_vec", proc_tms_vec, 0);
      check("mr_proc_tdi_vec", proc_tdi_vec, 0);
      check("mr_timeout_err", timeout_err, 0);
      model_hang = 1'b0;
      @(negedge clk);
      send_cmd(32);
      push_chunk(32, 32'h87654321, 32'h13579BDF, 32'h2468ACE0, 1, 1);
      wait_idle("after_rst");

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
